// File: rtl/ars_modsub.sv
// rtl/ars_modsub.sv - sequential modular subtractor c = (a - b) mod p
//
// Purpose: reduces a and b modulo p by restoring shift-subtract (one bit per
// cycle, fixed latency), then forms (a mod p) - (b mod p) and adds p back on
// borrow. Latency from the IDLE sampling edge to rdy is 2*SIZE+3 edges.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, priority over en
//   en   - level request: 0 clears to idle, 1 runs and holds the result
//   a    - minuend (sampled in IDLE)
//   b    - subtrahend (sampled in IDLE)
//   p    - modulus (sampled in IDLE)
//   rdy  - result valid, held until en=0 or rst
//   err  - p==0 detected, valid with rdy
//   c    - result in [0, p-1], 0 on err
module ars_modsub #(
  parameter int SIZE = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] p,
  output logic            rdy,
  output logic            err,
  output logic [SIZE-1:0] c
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RED_A, S_RED_B, S_SUB, S_FIX, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [SIZE-1:0] r_q, r_d, ra_q, ra_d, rb_q, rb_d;
  logic [SIZE:0]   d_q, d_d;
  logic [IW-1:0]   i_q, i_d;
  logic [SIZE-1:0] c_q, c_d;
  logic            rdy_q, rdy_d, err_q, err_d;

  // One restoring-division step. The running remainder is always < p, so it
  // fits SIZE bits; only the shifted value t needs the extra bit. When t >= p
  // the true difference is < p, so a SIZE-bit subtract is exact.
  logic            src_bit;
  logic [SIZE:0]   t;
  logic [SIZE-1:0] r_step;

  always_comb begin
    src_bit = (state_q == S_RED_A) ? a_q[i_q] : b_q[i_q];
    t       = {r_q, src_bit};
    r_step  = (t >= {1'b0, p_q}) ? (t[SIZE-1:0] - p_q) : t[SIZE-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r_d     = r_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    d_d     = d_q;
    i_d     = i_q;
    c_d     = c_q;
    rdy_d   = rdy_q;
    err_d   = err_q;

    if (!en) begin
      // Dropping the request aborts and clears exactly like reset.
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      p_d     = '0;
      r_d     = '0;
      ra_d    = '0;
      rb_d    = '0;
      d_d     = '0;
      i_d     = '0;
      c_d     = '0;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_d     = a;
          b_d     = b;
          p_d     = p;
          r_d     = '0;
          i_d     = IW'(SIZE - 1);
          state_d = (p == '0) ? S_ERR : S_RED_A;
        end
        S_RED_A: begin
          r_d = r_step;
          i_d = i_q - IW'(1);
          if (i_q == '0) begin
            ra_d    = r_step;
            r_d     = '0;
            i_d     = IW'(SIZE - 1);
            state_d = S_RED_B;
          end
        end
        S_RED_B: begin
          r_d = r_step;
          i_d = i_q - IW'(1);
          if (i_q == '0) begin
            rb_d    = r_step;
            state_d = S_SUB;
          end
        end
        S_SUB: begin
          d_d     = {1'b0, ra_q} - {1'b0, rb_q};
          state_d = S_FIX;
        end
        S_FIX: begin
          // Borrow means ra < rb; adding p lands in [0, p-1], carry dropped.
          c_d     = d_q[SIZE] ? (d_q[SIZE-1:0] + p_q) : d_q[SIZE-1:0];
          rdy_d   = 1'b1;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
        S_DONE: begin
          rdy_d = 1'b1;
          err_d = 1'b0;
        end
        S_ERR: begin
          rdy_d = 1'b1;
          err_d = 1'b1;
          c_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      d_q     <= '0;
      i_q     <= '0;
      c_q     <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      d_q     <= d_d;
      i_q     <= i_d;
      c_q     <= c_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign rdy = rdy_q;
  assign err = err_q;
  assign c   = c_q;

endmodule

// File: tb/tb_ars_modsub.sv
// tb/tb_ars_modsub.sv - self-checking bench for ars_modsub (SIZE=8 and SIZE=256)
module tb_ars_modsub;

  logic         clk;
  logic         rst;
  logic         en8, en256;
  logic [7:0]   a8, b8, p8, c8;
  logic         rdy8, err8;
  logic [255:0] a256, b256, p256, c256;
  logic         rdy256, err256;

  int vectors;
  int miscompares;

  ars_modsub #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .p(p8),
    .rdy(rdy8), .err(err8), .c(c8)
  );

  ars_modsub #(.SIZE(256)) u_dut256 (
    .clk(clk), .rst(rst), .en(en256), .a(a256), .b(b256), .p(p256),
    .rdy(rdy256), .err(err256), .c(c256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model8(input int a, input int b, input int p);
    return ((a % p) - (b % p) + p) % p;
  endfunction

  function automatic logic [255:0] model256(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] p);
    logic [257:0] ar, br, pp;
    pp = {2'b00, p};
    ar = {2'b00, a} % pp;
    br = {2'b00, b} % pp;
    model256 = 256'((ar + pp - br) % pp);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                      output int edges);
    a8 = a; b8 = b; p8 = p; en8 = 1'b1;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (rdy8) break;
    end
  endtask

  task automatic run256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] p,
                        output int edges);
    a256 = a; b256 = b; p256 = p; en256 = 1'b1;
    edges = 0;
    while (edges < 700) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (rdy256) break;
    end
  endtask

  task automatic drop8();
    en8 = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en8 = 1'b0; en256 = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    vectors++;
    if (rdy8 !== 1'b0 || err8 !== 1'b0 || c8 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset8 rdy=%b err=%b c=%0d want 0 0 0", rdy8, err8, c8);
    end
    vectors++;
    if (rdy256 !== 1'b0 || err256 !== 1'b0 || c256 !== 256'd0) begin
      miscompares++;
      $display("FAIL reset256_en_high rdy=%b err=%b c=%0h want 0 0 0", rdy256, err256, c256);
    end
    en256 = 1'b0;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    run8(8'd20, 8'd7, 8'd23, e);
    vectors++;
    if (e != 19) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 19", e);
    end
    vectors++;
    if (c8 !== 8'd13 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result c=%0d err=%b want 13 0", c8, err8);
    end
    for (int k = 0; k < 4; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom);
      @(posedge clk); @(negedge clk);
      vectors++;
      if (rdy8 !== 1'b1 || c8 !== 8'd13 || err8 !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_hold%0d rdy=%b c=%0d err=%b want 1 13 0", k, rdy8, c8, err8);
      end
    end
    drop8();
    vectors++;
    if (rdy8 !== 1'b0 || c8 !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_drop rdy=%b c=%0d want 0 0", rdy8, c8);
    end
  endtask

  task automatic test_boundaries8();
    int tbl [6][3] = '{'{3, 10, 23}, '{9, 9, 23}, '{250, 5, 7}, '{200, 17, 1},
                       '{255, 0, 255}, '{0, 254, 255}};
    int e, exp;
    for (int k = 0; k < 6 + 20; k++) begin
      int a, b, p;
      if (k < 6) begin
        a = tbl[k][0]; b = tbl[k][1]; p = tbl[k][2];
      end else begin
        a = $urandom_range(0, 255); b = $urandom_range(0, 255); p = $urandom_range(1, 255);
      end
      exp = model8(a, b, p);
      run8(8'(a), 8'(b), 8'(p), e);
      vectors++;
      if (e != 19 || c8 !== 8'(exp) || err8 !== 1'b0) begin
        miscompares++;
        $display("FAIL vec8 a=%0d b=%0d p=%0d got c=%0d err=%b edges=%0d want c=%0d err=0 edges=19",
                 a, b, p, c8, err8, e, exp);
      end
      drop8();
    end
  endtask

  task automatic test_p_zero();
    int e;
    run8(8'd77, 8'd3, 8'd0, e);
    vectors++;
    if (e != 2 || rdy8 !== 1'b1 || err8 !== 1'b1 || c8 !== 8'd0) begin
      miscompares++;
      $display("FAIL p_zero edges=%0d rdy=%b err=%b c=%0d want 2 1 1 0", e, rdy8, err8, c8);
    end
    drop8();
    vectors++;
    if (rdy8 !== 1'b0 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL p_zero_clear rdy=%b err=%b want 0 0", rdy8, err8);
    end
  endtask

  task automatic test_abort_en();
    int e;
    a8 = 8'd3; b8 = 8'd10; p8 = 8'd23; en8 = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    en8 = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (rdy8 !== 1'b0 || c8 !== 8'd0) begin
      miscompares++;
      $display("FAIL abort_en rdy=%b c=%0d want 0 0", rdy8, c8);
    end
    run8(8'd3, 8'd10, 8'd23, e);
    vectors++;
    if (e != 19 || c8 !== 8'd16) begin
      miscompares++;
      $display("FAIL abort_en_rerun edges=%0d c=%0d want 19 16", e, c8);
    end
    drop8();
  endtask

  task automatic test_abort_rst();
    int e;
    a8 = 8'd3; b8 = 8'd10; p8 = 8'd23; en8 = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (rdy8 !== 1'b0 || c8 !== 8'd0 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_rst rdy=%b c=%0d err=%b want 0 0 0", rdy8, c8, err8);
    end
    rst = 1'b0;
    e = 0;
    while (e < 100) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (rdy8) break;
    end
    vectors++;
    if (e != 19 || c8 !== 8'd16) begin
      miscompares++;
      $display("FAIL abort_rst_rerun edges=%0d c=%0d want 19 16", e, c8);
    end
    drop8();
  endtask

  task automatic test_random256();
    int e;
    logic [255:0] a, b, p, exp;
    for (int k = 0; k < 50; k++) begin
      case (k % 5)
        0: p = '1;
        1: p = 256'd2;
        2: p = 256'($urandom_range(1, 65535));
        3: p = rand256();
        default: p = rand256() >> $urandom_range(0, 250);
      endcase
      if (p == '0) p = 256'd1;
      a = rand256();
      b = (k % 3 == 0) ? (rand256() % p) : rand256();
      if (k == 7) b = a;
      exp = model256(a, b, p);
      run256(a, b, p, e);
      vectors++;
      if (e != 515 || c256 !== exp || err256 !== 1'b0) begin
        miscompares++;
        $display("FAIL vec256 k=%0d edges=%0d err=%b c=%0h want edges=515 err=0 c=%0h",
                 k, e, err256, c256, exp);
      end
      en256 = 1'b0;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; en8 = 1'b0; en256 = 1'b0;
    a8 = '0; b8 = '0; p8 = '0;
    a256 = '0; b256 = '0; p256 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundaries8();
    test_p_zero();
    test_abort_en();
    test_abort_rst();
    test_random256();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
